// File: rtl/alu_pkg.sv
// Shared ALU constants: default datapath width, the most-negative operand,
// and bit positions of the result flags in the processor status word.
package alu_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [WIDTH_DEF-1:0] MIN_NEG = {1'b1, {(WIDTH_DEF-1){1'b0}}};

   localparam int FLAG_OVF  = 0;
   localparam int FLAG_ZERO = 1;
   localparam int FLAG_NEG  = 2;
   localparam int NFLAGS    = 3;

   // Most-negative two's-complement value for an arbitrary width.
   function automatic logic [WIDTH_DEF-1:0] min_neg_of(input int w);
      logic [WIDTH_DEF-1:0] v;
      v = '0;
      v[w-1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/inc_cla.sv
// WIDTH-bit incrementer (a + 1) built from 4-bit carry-lookahead groups.
// Group carries are chained through group propagate terms; no adder operator.
module inc_cla
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NG = (WIDTH + 3) / 4;
   localparam int PW = NG * 4;

   logic [PW-1:0] a_pad;
   logic [PW:0]   c;
   logic [NG:0]   gc;
   logic [NG-1:0] gp;
   logic          pre;

   // An incrementer has no generate terms: a carry reaches a bit only when
   // every lower bit in its group is 1 and the group itself receives a carry.
   always_comb begin
      a_pad = '0;
      a_pad[WIDTH-1:0] = a;
      c     = '0;
      gc    = '0;
      gp    = '0;
      pre   = 1'b0;
      gc[0] = 1'b1;
      for (int g = 0; g < NG; g++) begin
         pre = 1'b1;
         for (int j = 0; j < 4; j++) begin
            c[g*4+j] = gc[g] & pre;
            pre      = pre & a_pad[g*4+j];
         end
         gp[g]   = pre;
         gc[g+1] = gc[g] & gp[g];
      end
      c[PW] = gc[NG];
   end

   assign sum  = a ^ c[WIDTH-1:0];
   assign cout = c[WIDTH];

endmodule

// File: rtl/neg_new_unit.sv
// Two's-complement negation for the ALU NEG instruction: combinational y = -x
// plus a one-cycle registered copy with overflow/zero/sign flags.
module neg_new_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] x,
   input  logic             in_valid,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             out_valid,
   output logic             ovf_q,
   output logic             zero_q,
   output logic             neg_q
);

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic              inc_cout;
   logic [NFLAGS-1:0] flags;
   logic [NFLAGS-1:0] flags_q;

   inc_cla #(.WIDTH(WIDTH)) u_inc (
      .a    (~x),
      .sum  (y),
      .cout (inc_cout)
   );

   // The carry out of ~x + 1 is set only for x == 0, i.e. exactly when y == 0.
   always_comb begin
      flags            = '0;
      flags[FLAG_OVF]  = (x == MIN_VAL);
      flags[FLAG_ZERO] = inc_cout;
      flags[FLAG_NEG]  = y[WIDTH-1];
   end

   // in_valid qualifies x for one cycle; out_valid follows one cycle later.
   // There is no ready: the consumer must take each result when it appears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q       <= '0;
         flags_q   <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            y_q     <= y;
            flags_q <= flags;
         end
      end
   end

   assign ovf_q  = flags_q[FLAG_OVF];
   assign zero_q = flags_q[FLAG_ZERO];
   assign neg_q  = flags_q[FLAG_NEG];

endmodule

// File: tb/tb_neg_new_unit.sv
// Directed and swept checks of neg_new_unit: combinational negation, flags,
// one-cycle registered path, valid gating and asynchronous reset.
module tb_neg_new_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] x = '0;
   logic         in_valid = 1'b0;
   logic [W-1:0] y;
   logic [W-1:0] y_q;
   logic         out_valid;
   logic         ovf_q;
   logic         zero_q;
   logic         neg_q;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         ovf;
      logic         zero;
      logic         neg;
   } vec_t;

   localparam int NV = 10;
   vec_t tbl[NV];

   logic [W-1:0] exp_q[$];
   logic [W-1:0] held;
   logic [W-1:0] exp_v;
   logic [W-1:0] rx;
   logic         rv;

   neg_new_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .x         (x),
      .in_valid  (in_valid),
      .y         (y),
      .y_q       (y_q),
      .out_valid (out_valid),
      .ovf_q     (ovf_q),
      .zero_q    (zero_q),
      .neg_q     (neg_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_reg(input vec_t v);
      chk("out_valid", W'(out_valid), W'(1'b1));
      chk("y_q",       y_q,           v.y);
      chk("ovf_q",     W'(ovf_q),     W'(v.ovf));
      chk("zero_q",    W'(zero_q),    W'(v.zero));
      chk("neg_q",     W'(neg_q),     W'(v.neg));
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, " y_q"},       y_q,           '0);
      chk({tag, " out_valid"}, W'(out_valid), '0);
      chk({tag, " ovf_q"},     W'(ovf_q),     '0);
      chk({tag, " zero_q"},    W'(zero_q),    '0);
      chk({tag, " neg_q"},     W'(neg_q),     '0);
   endtask

   initial begin
      // x, -x, ovf, zero, neg (hand computed)
      tbl[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
      tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{32'h0000_001D, 32'hFFFF_FFE3, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{32'h7FFF_FFFF, 32'h8000_0001, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{32'h1234_5678, 32'hEDCB_A988, 1'b0, 1'b0, 1'b1};
      tbl[7] = '{32'h0000_0010, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1};
      tbl[8] = '{32'h0001_0000, 32'hFFFF_0000, 1'b0, 1'b0, 1'b1};
      tbl[9] = '{32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0};

      // Reset state, and combinational y working while reset is held.
      #1;
      chk_cleared("reset");
      x = 32'd29;
      #10;
      chk("settle y", y, 32'hFFFF_FFE3);

      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back valid table: comb check now, registered check next cycle.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         if (i > 0) chk_reg(tbl[i-1]);
         x = tbl[i].x;
         in_valid = 1'b1;
         #1;
         chk("y comb", y, tbl[i].y);
      end
      @(negedge clk);
      chk_reg(tbl[NV-1]);
      in_valid = 1'b0;
      x = 32'h0000_0042;

      // Invalid cycle: out_valid drops, y_q and flags hold.
      @(negedge clk);
      chk("hold out_valid", W'(out_valid), '0);
      chk_reg_hold: begin
         chk("hold y_q",    y_q,        tbl[NV-1].y);
         chk("hold neg_q",  W'(neg_q),  W'(tbl[NV-1].neg));
         chk("hold zero_q", W'(zero_q), W'(tbl[NV-1].zero));
      end

      // Asynchronous reset mid-stream while out_valid is high.
      x = 32'd5;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      chk("pre-reset out_valid", W'(out_valid), W'(1'b1));
      chk("pre-reset y_q",       y_q,           32'hFFFF_FFFB);
      rst_n = 1'b0;
      #1;
      chk_cleared("async");
      chk("y under reset", y, 32'hFFFF_FFFB);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-reset out_valid", W'(out_valid), '0);
      chk("post-reset y_q",       y_q,           '0);

      // First capture after reset release.
      x = 32'd3;
      in_valid = 1'b1;
      @(negedge clk);
      chk("first out_valid", W'(out_valid), W'(1'b1));
      chk("first y_q",       y_q,           32'hFFFF_FFFD);
      in_valid = 1'b0;
      held = 32'hFFFF_FFFD;

      // Random sweep with an expected queue for the registered path.
      @(negedge clk);
      for (int n = 0; n < 10000; n++) begin
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            held  = exp_v;
            chk("sweep out_valid", W'(out_valid), W'(1'b1));
            chk("sweep y_q",       y_q,           exp_v);
         end else begin
            chk("sweep idle out_valid", W'(out_valid), '0);
            chk("sweep idle y_q",       y_q,           held);
         end
         rx = $urandom;
         rv = ($urandom_range(0, 3) != 0);
         x = rx;
         in_valid = rv;
         #1;
         chk("sweep y", y, W'(0 - rx));
         if (rv) exp_q.push_back(W'(0 - rx));
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         chk("drain out_valid", W'(out_valid), W'(1'b1));
         chk("drain y_q",       y_q,           exp_v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
